// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor: widths, instruction field positions,
// the HALT encoding and the fetch-stage state encoding.
package cpu_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int IMM_DATA_WIDTH = 7;

    // Instruction format: [15:13] op, [12:10] rs, [9:7] rt, [6:0] imm
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RS_MSB  = 12;
    localparam int RS_LSB  = 10;
    localparam int RT_MSB  = 9;
    localparam int RT_LSB  = 7;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;

    localparam logic [DATA_WIDTH-1:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    function automatic logic is_halt_word(input logic [DATA_WIDTH-1:0] word);
        return (word == HALT_WORD);
    endfunction

endpackage

// File: rtl/instr_fetch_stage_pc_counter.sv
// Program counter: reset load, redirect load and +1 increment (wraps modulo 2^16).
module pc_counter
    import cpu_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_pc,
    input  logic                  inc,
    output logic [DATA_WIDTH-1:0] pc
);

    // PC register; redirect load wins over sequential increment
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + DATA_WIDTH'(1);
        end else begin
            pc <= pc;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, requests instruction words and holds the fetched word for decode.
// Optional HALT support is compiled in when the macro IFETCH_HALT_EN is defined.
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 16'h0000
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [DATA_WIDTH-1:0]     imem_addr,
    input  logic [DATA_WIDTH-1:0]     imem_rdata,
    input  logic                      imem_valid,
    input  logic                      redirect_valid,
    input  logic [DATA_WIDTH-1:0]     redirect_pc,
    input  logic                      stall,
    output logic                      ifid_valid,
    output logic [DATA_WIDTH-1:0]     ifid_pc,
    output logic [DATA_WIDTH-1:0]     ifid_instr,
    output logic [OP_MSB-OP_LSB:0]    ifid_opcode,
    output logic [RS_MSB-RS_LSB:0]    ifid_rs,
    output logic [RT_MSB-RT_LSB:0]    ifid_rt,
    output logic [IMM_DATA_WIDTH-1:0] ifid_imm,
    output logic                      halted
);

    fetch_state_t          state_r;
    fetch_state_t          state_nxt_s;
    logic                  drop_r;
    logic [DATA_WIDTH-1:0] skid_r;
    logic [DATA_WIDTH-1:0] pc_s;
    logic [DATA_WIDTH-1:0] load_word_s;
    logic                  resp_s;
    logic                  accept_s;
    logic                  capture_s;
    logic                  release_s;
    logic                  load_s;
    logic                  halt_hit_s;
    logic                  pc_inc_s;

    // A live response is one not owed to a request abandoned by an earlier redirect
    assign resp_s      = (state_r == REQ) && imem_valid && !drop_r && !redirect_valid;
    assign accept_s    = resp_s && !stall;
    assign capture_s   = resp_s && stall;
    assign release_s   = (state_r == HOLD) && !stall && !redirect_valid;
    assign load_s      = accept_s || release_s;
    assign load_word_s = accept_s ? imem_rdata : skid_r;
    assign pc_inc_s    = load_s && !halt_hit_s;

    pc_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .inc     (pc_inc_s),
        .pc      (pc_s)
    );

    // Fetch FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fetch FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        if (redirect_valid) begin
            state_nxt_s = REQ;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = halted ? IDLE : REQ;
                REQ: begin
                    if (capture_s) begin
                        state_nxt_s = HOLD;
                    end else if (accept_s && halt_hit_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = REQ;
                    end
                end
                HOLD: begin
                    if (release_s) begin
                        state_nxt_s = halt_hit_s ? IDLE : REQ;
                    end else begin
                        state_nxt_s = HOLD;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Fetch FSM outputs
    always_comb begin
        imem_req = 1'b0;
        case (state_r)
            REQ:     imem_req = 1'b1;
            IDLE:    imem_req = 1'b0;
            HOLD:    imem_req = 1'b0;
            default: imem_req = 1'b0;
        endcase
    end

    assign imem_addr = pc_s;

    // Drop flag: set when a redirect abandons a request still waiting for its response
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_r <= 1'b0;
        end else if (redirect_valid) begin
            drop_r <= (state_r == REQ) && !imem_valid;
        end else if ((state_r == REQ) && imem_valid) begin
            drop_r <= 1'b0;
        end else begin
            drop_r <= drop_r;
        end
    end

    // Skid register holds the one word that arrived while decode was stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_r <= {DATA_WIDTH{1'b0}};
        end else if (redirect_valid) begin
            skid_r <= {DATA_WIDTH{1'b0}};
        end else if (capture_s) begin
            skid_r <= imem_rdata;
        end else begin
            skid_r <= skid_r;
        end
    end

    // Fetch/decode register; valid drops to a bubble when decode consumed it and nothing new arrived
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= {DATA_WIDTH{1'b0}};
            ifid_instr <= {DATA_WIDTH{1'b0}};
        end else if (redirect_valid) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= ifid_pc;
            ifid_instr <= ifid_instr;
        end else if (load_s) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= pc_s;
            ifid_instr <= load_word_s;
        end else if (!stall) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= ifid_pc;
            ifid_instr <= ifid_instr;
        end else begin
            ifid_valid <= ifid_valid;
            ifid_pc    <= ifid_pc;
            ifid_instr <= ifid_instr;
        end
    end

    assign ifid_opcode = ifid_instr[OP_MSB:OP_LSB];
    assign ifid_rs     = ifid_instr[RS_MSB:RS_LSB];
    assign ifid_rt     = ifid_instr[RT_MSB:RT_LSB];
    assign ifid_imm    = ifid_instr[IMM_MSB:IMM_LSB];

`ifdef IFETCH_HALT_EN
    logic halted_r;

    assign halt_hit_s = load_s && is_halt_word(load_word_s);
    assign halted     = halted_r;

    // Halt flag: set by loading the HALT word, cleared only by reset or redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r <= 1'b0;
        end else if (redirect_valid) begin
            halted_r <= 1'b0;
        end else if (halt_hit_s) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end
`else
    assign halt_hit_s = 1'b0;
    assign halted     = 1'b0;
`endif

endmodule
